alu_result_collector: RTL
=========================

Name: alu_result_collector

Overview:
Sequencing and capture block on the result side of the ALU. Accepts an issue request with an opcode and holds it stable while the combinational ALU settles. Multiply and divide settle over a longer multicycle window than the other operations. Once the result has settled, the block latches Z, or HI/LO for multiply and divide, into architectural result registers. It then signals completion and returns the captured values to the datapath bus through a registered read port.

Parameters:
MULDIV_CYCLES, 4, settle cycles waited after issue for opcodes 01111 (MUL) and 10000 (DIV); must be >= 1
SIMPLE_CYCLES, 1, settle cycles waited after issue for all other legal opcodes; must be >= 1
CNT_W, 4, width of the settle counter; must hold max(MULDIV_CYCLES, SIMPLE_CYCLES)

Ports:
clock  in  1  single system clock, rising edge
clear  in  1  asynchronous, active-high reset
start  in  1  issue request, sampled only in IDLE
opcode_in  in  5  operation code presented with start
opcode_out  out  5  latched opcode driven to the ALU opcode input
Z_in  in  32  ALU Z result
Zhigh_in  in  32  ALU high result (MUL/DIV)
Zlow_in  in  32  ALU low result (MUL/DIV)
busy  out  1  high from the cycle after an accepted start until the return to IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when the opcode is illegal
Z_q  out  32  captured Z register
HI_q  out  32  captured high register
LO_q  out  32  captured low register
zero_flag  out  1  set when the last captured primary result equals 0
neg_flag  out  1  bit 31 of the last captured primary result
rd_en  in  1  bus read enable
rd_sel  in  2  read source: 00 Z_q, 01 HI_q, 10 LO_q, 11 constant 0
bus_out  out  32  registered read data

Behaviour:
- Reset: clear=1 forces, asynchronously, state=IDLE and counter=0. It also forces every output to 0: opcode_out, busy, done, err, Z_q, HI_q, LO_q, zero_flag, neg_flag and bus_out. A reset asserted mid-operation abandons the operation; no done pulse is produced.
- Legal opcodes: 01010 AND, 01011 OR, 00011 ADD, 00100 SUB, 01111 MUL, 10000 DIV, 00101 SHR, 00110 SHRA, 00111 SHL, 01000 ROR, 01001 ROL, 10001 NEG, 10010 NOT. All other codes are illegal.
- States: IDLE, SETTLE, CAPTURE.
- IDLE, start=1 and legal opcode:
  - latch opcode_out <= opcode_in;
  - load counter <= MULDIV_CYCLES for MUL/DIV, otherwise SIMPLE_CYCLES;
  - go to SETTLE; busy=1 from the next cycle.
- IDLE, start=1 and illegal opcode:
  - stay in IDLE; no register write;
  - pulse done=1 and err=1 in the next cycle; busy stays 0.
- SETTLE: counter decrements once per cycle. When counter==1, the next state is CAPTURE. Total issue-to-done latency is N+2 cycles, where N is the selected settle count.
- CAPTURE, MUL/DIV:
  - HI_q <= Zhigh_in, LO_q <= Zlow_in; Z_q unchanged;
  - zero_flag = (Zlow_in==0 && Zhigh_in==0);
  - neg_flag = Zhigh_in[31].
- CAPTURE, other opcodes:
  - Z_q <= Z_in; HI_q and LO_q unchanged;
  - zero_flag = (Z_in==0), neg_flag = Z_in[31].
- CAPTURE exit: done=1 and busy=0 in the following cycle, state returns to IDLE. opcode_out holds its value until the next accepted start.
- start while busy (SETTLE/CAPTURE): ignored and not queued.
- start on the same cycle that done is high: accepted normally, giving back-to-back operation.
- Read port:
  - each cycle with rd_en=1, bus_out <= the source selected by rd_sel (one-cycle latency);
  - rd_en=0 holds bus_out;
  - a read in the same cycle as CAPTURE returns the pre-capture register value.
- Arithmetic: no computation in this block; values are captured verbatim and results are never sign- or zero-extended.

Test Plan:
- Reset: assert clear mid-SETTLE of a MUL -> all outputs read 0 immediately, no done pulse, IDLE after release.
- ADD: start with opcode 00011 and Z_in=0x0000_0007 (SIMPLE_CYCLES=1) -> done 3 cycles after start, Z_q=0x7, zero_flag=0, neg_flag=0, HI_q/LO_q unchanged.
- MUL: start with opcode 01111, Zhigh_in=0xFFFF_FFFF, Zlow_in=0xFFFF_FFFE (MULDIV_CYCLES=4) -> done at cycle 6, HI_q=0xFFFF_FFFF, LO_q=0xFFFF_FFFE, neg_flag=1, Z_q unchanged.
- Illegal: start with opcode 11111 -> done=1 and err=1 in the next cycle, busy never asserts, registers unchanged.
- Busy: second start (SUB) during the SETTLE of a DIV -> ignored, a single done pulse. A start on the done cycle -> accepted, busy rises the next cycle.
- Read port: after SUB with Z_in=0 (zero_flag=1), rd_en=1 for rd_sel 00/01/10/11 on consecutive cycles -> bus_out returns Z_q, HI_q, LO_q, 0, each one cycle later.

Source files
------------

// File: rtl/alu_result_collector.sv
// Result-side sequencer for the ALU: holds the issued opcode while the ALU settles,
// captures Z or HI/LO into architectural registers, and serves them on a registered read port.
`timescale 1ns/1ps
module alu_result_collector #(
    parameter int MULDIV_CYCLES = 4,
    parameter int SIMPLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode_in,
    output logic [4:0]  opcode_out,
    input  logic [31:0] Z_in,
    input  logic [31:0] Zhigh_in,
    input  logic [31:0] Zlow_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] Z_q,
    output logic [31:0] HI_q,
    output logic [31:0] LO_q,
    output logic        zero_flag,
    output logic        neg_flag,
    input  logic        rd_en,
    input  logic [1:0]  rd_sel,
    output logic [31:0] bus_out
);

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic             legal;
    logic             accept;
    logic             reject;
    logic             issue_muldiv;
    logic             held_muldiv;

    always_comb begin
        legal = 1'b0;
        case (opcode_in)
            5'b01010, 5'b01011, 5'b00011, 5'b00100, 5'b01111, 5'b10000, 5'b00101,
            5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b10001, 5'b10010: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign issue_muldiv = (opcode_in == OP_MUL) || (opcode_in == OP_DIV);
    assign held_muldiv  = (opcode_out == OP_MUL) || (opcode_out == OP_DIV);
    assign busy         = (state != IDLE);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        accept     = 1'b1;
                        state_next = SETTLE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (count == CNT_W'(1)) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count      <= '0;
            opcode_out <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            Z_q        <= '0;
            HI_q       <= '0;
            LO_q       <= '0;
            zero_flag  <= 1'b0;
            neg_flag   <= 1'b0;
        end else begin
            done <= (state == CAPTURE) || reject;
            err  <= reject;
            if (accept) begin
                opcode_out <= opcode_in;
                count      <= issue_muldiv ? CNT_W'(MULDIV_CYCLES) : CNT_W'(SIMPLE_CYCLES);
            end else if (state == SETTLE) begin
                count <= count - CNT_W'(1);
            end
            // MUL/DIV flags describe the 64-bit HI:LO pair; everything else describes Z.
            if (state == CAPTURE) begin
                if (held_muldiv) begin
                    HI_q      <= Zhigh_in;
                    LO_q      <= Zlow_in;
                    zero_flag <= (Zhigh_in == '0) && (Zlow_in == '0);
                    neg_flag  <= Zhigh_in[31];
                end else begin
                    Z_q       <= Z_in;
                    zero_flag <= (Z_in == '0);
                    neg_flag  <= Z_in[31];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_out <= '0;
        end else if (rd_en) begin
            case (rd_sel)
                2'b00:   bus_out <= Z_q;
                2'b01:   bus_out <= HI_q;
                2'b10:   bus_out <= LO_q;
                default: bus_out <= '0;
            endcase
        end
    end

endmodule
